// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types, constants and segment table for the seven-segment scanner
package seven_seg_pkg;

  typedef enum logic {BLANK, ON} scan_state_t;

  localparam int DIGITS    = 4;
  localparam int PWM_STEPS = 8;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low segment decoder
module hex_to_seg7 (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);
  import seven_seg_pkg::*;

  assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - 4-digit multiplexed seven-segment scanner with blanking and PWM dimming
module seven_seg_scanner #(
  parameter int PRESCALE    = 1000,
  parameter int BLANK_TICKS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] display,
  input  logic [3:0]  points,
  input  logic [3:0]  enable_digits,
  input  logic [2:0]  brightness,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done
);
  import seven_seg_pkg::*;

  localparam int PW   = $clog2(PRESCALE);
  localparam int MAXT = (BLANK_TICKS > PWM_STEPS) ? BLANK_TICKS : PWM_STEPS;
  localparam int TW   = $clog2(MAXT);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  scan_state_t   state, state_d;
  logic [1:0]    digit, digit_d;
  logic [TW-1:0] tick_cnt, tick_cnt_d;
  logic          frame_end;
  logic          frame_start;

  logic [15:0]   sh_disp;
  logic [3:0]    sh_points;
  logic [3:0]    sh_en;
  logic [2:0]    sh_bright;

  logic [3:0]    nibble;
  logic [6:0]    dec_seg;
  logic          lit;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  assign tick = (pre_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) pre_cnt <= '0;
    else               pre_cnt <= pre_cnt + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BLANK;
      digit    <= 2'd3;
      tick_cnt <= '0;
    end else begin
      state    <= state_d;
      digit    <= digit_d;
      tick_cnt <= tick_cnt_d;
    end
  end

  always_comb begin
    state_d    = state;
    digit_d    = digit;
    tick_cnt_d = tick_cnt;
    frame_end  = 1'b0;
    if (tick) begin
      tick_cnt_d = tick_cnt + TW'(1);
      case (state)
        BLANK: begin
          if (tick_cnt == TW'(BLANK_TICKS - 1)) begin
            state_d    = ON;
            tick_cnt_d = '0;
          end
        end
        ON: begin
          if (tick_cnt == TW'(PWM_STEPS - 1)) begin
            state_d    = BLANK;
            tick_cnt_d = '0;
            digit_d    = digit - 2'd1;
            frame_end  = (digit == 2'd0);
          end
        end
        default: ;
      endcase
    end
  end

  // Only the currently scanned digit's shadow nibble reaches the decoder.
  assign nibble = sh_disp[{digit, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg_n  (dec_seg)
  );

  assign lit   = (state == ON) && sh_en[digit] && (tick_cnt <= TW'(sh_bright));
  assign an_d  = lit ? ~(4'b0001 << digit) : 4'hF;
  assign seg_d = lit ? dec_seg : 7'h7F;
  assign dp_d  = lit ? sh_points[digit] : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      an_n        <= 4'hF;
      seg_n       <= 7'h7F;
      dp_n        <= 1'b1;
      frame_done  <= 1'b0;
      frame_start <= 1'b1;
      sh_disp     <= '0;
      sh_points   <= 4'hF;
      sh_en       <= '0;
      sh_bright   <= '0;
    end else begin
      an_n        <= an_d;
      seg_n       <= seg_d;
      dp_n        <= dp_d;
      frame_done  <= frame_end;
      frame_start <= frame_end;
      if (frame_start) begin
        // Disabled digits may carry z; store a clean zero instead.
        for (int i = 0; i < DIGITS; i++)
          sh_disp[i*4 +: 4] <= enable_digits[i] ? display[i*4 +: 4] : 4'h0;
        sh_points <= points;
        sh_en     <= enable_digits;
        sh_bright <= brightness;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - self-checking bench for seven_seg_scanner against a frame-timing model
module tb_seven_seg_scanner;

  localparam int P     = 2;
  localparam int B     = 1;
  localparam int SLOT  = (B + 8) * P;
  localparam int FRAME = 4 * SLOT;

  localparam logic [6:0] SEG_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [12:0] RESET_VEC = {4'hF, 7'h7F, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] display = '0;
  logic [3:0]  points = 4'hF;
  logic [3:0]  enable_digits = '0;
  logic [2:0]  brightness = '0;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  int t = 0;
  logic [15:0] s_disp = '0;
  logic [3:0]  s_pts = 4'hF;
  logic [3:0]  s_en = '0;
  logic [2:0]  s_br = '0;
  logic [12:0] got, exp;

  always #5 clk = ~clk;

  seven_seg_scanner #(.PRESCALE(P), .BLANK_TICKS(B)) dut (
    .clk           (clk),
    .reset         (reset),
    .display       (display),
    .points        (points),
    .enable_digits (enable_digits),
    .brightness    (brightness),
    .an_n          (an_n),
    .seg_n         (seg_n),
    .dp_n          (dp_n),
    .frame_done    (frame_done)
  );

  // Expected outputs in cycle tc after release: they show the scan position of cycle tc-1.
  function automatic logic [12:0] expect_at(int tc);
    int u, pos, d, k;
    logic on_now, lit;
    if (tc == 0) return RESET_VEC;
    u      = tc - 1;
    pos    = u % SLOT;
    d      = 3 - (u / SLOT) % 4;
    on_now = (pos >= B * P);
    k      = on_now ? (pos - B * P) / P : 0;
    lit    = on_now && s_en[d] && (k <= int'(s_br));
    return {lit ? (4'hF ^ (4'b0001 << d)) : 4'hF,
            lit ? SEG_REF[s_disp[4*d +: 4]] : 7'h7F,
            lit ? s_pts[d] : 1'b1,
            (u % FRAME) == FRAME - 1};
  endfunction

  task automatic set_inputs(input logic [15:0] d, input logic [3:0] p,
                            input logic [3:0] e, input logic [2:0] b);
    display = d; points = p; enable_digits = e; brightness = b;
  endtask

  // Moves one clock; a frame-start cycle latches the model snapshot, a reset restarts the count.
  task automatic advance();
    if (reset) begin
      @(posedge clk); #1;
      reset = 1'b0;
      t = 0;
    end else begin
      if (t % FRAME == 0) begin
        s_disp = display; s_pts = points; s_en = enable_digits; s_br = brightness;
      end
      @(posedge clk); #1;
      t++;
    end
  endtask

  task automatic test_reset();
    set_inputs(16'($urandom), 4'($urandom), 4'($urandom), 3'($urandom));
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      got = {an_n, seg_n, dp_n, frame_done}; checks++;
      if (got !== RESET_VEC) begin
        failures++; $display("FAIL reset_hold got=%h exp=%h", got, RESET_VEC);
      end
    end
    advance();
    for (int i = 0; i < 8; i++) begin
      exp = expect_at(t); got = {an_n, seg_n, dp_n, frame_done}; checks++;
      if (got !== exp) begin
        failures++; $display("FAIL reset_release t=%0d got=%h exp=%h", t, got, exp);
      end
      advance();
    end
  endtask

  task automatic test_full_frame();
    int fd_count = 0;
    set_inputs(16'h8888, 4'hF, 4'hF, 3'd7);
    reset = 1'b1; advance();
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      exp = expect_at(t); got = {an_n, seg_n, dp_n, frame_done}; checks++;
      if (got !== exp) begin
        failures++; $display("FAIL full_frame t=%0d got=%h exp=%h", t, got, exp);
      end
      fd_count += int'(frame_done);
      advance();
    end
    checks++;
    if (fd_count != 2) begin
      failures++; $display("FAIL frame_done_count got=%0d exp=2", fd_count);
    end
  endtask

  task automatic test_brightness0();
    int lit_cycles = 0;
    set_inputs(16'h8888, 4'hF, 4'hF, 3'd0);
    reset = 1'b1; advance();
    for (int i = 0; i <= FRAME; i++) begin
      exp = expect_at(t); got = {an_n, seg_n, dp_n, frame_done}; checks++;
      if (got !== exp) begin
        failures++; $display("FAIL brightness0 t=%0d got=%h exp=%h", t, got, exp);
      end
      if (t >= 1 && an_n != 4'hF) lit_cycles++;
      advance();
    end
    checks++;
    if (lit_cycles != 4 * P) begin
      failures++; $display("FAIL brightness0_on_time got=%0d exp=%0d", lit_cycles, 4 * P);
    end
  endtask

  task automatic test_enable_partial();
    set_inputs(16'h01zz, 4'hF, 4'b1100, 3'd7);
    reset = 1'b1; advance();
    for (int i = 0; i < FRAME + 4; i++) begin
      exp = expect_at(t); got = {an_n, seg_n, dp_n, frame_done}; checks++;
      if (got !== exp || $isunknown(seg_n)) begin
        failures++; $display("FAIL enable_partial t=%0d got=%h exp=%h", t, got, exp);
      end
      advance();
    end
  endtask

  task automatic test_points();
    set_inputs(16'($urandom), 4'b1101, 4'hF, 3'd7);
    reset = 1'b1; advance();
    for (int i = 0; i < FRAME + 4; i++) begin
      exp = expect_at(t); got = {an_n, seg_n, dp_n, frame_done}; checks++;
      if (got !== exp || (dp_n == 1'b0 && an_n != 4'b1101)) begin
        failures++; $display("FAIL points t=%0d got=%h exp=%h", t, got, exp);
      end
      advance();
    end
  endtask

  task automatic test_mid_frame();
    set_inputs(16'h1111, 4'hF, 4'hF, 3'd7);
    reset = 1'b1; advance();
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      exp = expect_at(t); got = {an_n, seg_n, dp_n, frame_done}; checks++;
      if (got !== exp) begin
        failures++; $display("FAIL mid_frame t=%0d got=%h exp=%h", t, got, exp);
      end
      if (t == SLOT + 3) display = 16'h2222;
      advance();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic restarted = 1'b0;
    set_inputs(16'h8888, 4'hF, 4'hF, 3'd7);
    reset = 1'b1; advance();
    for (int i = 0; i < 110; i++) begin
      exp = expect_at(t); got = {an_n, seg_n, dp_n, frame_done}; checks++;
      if (got !== exp) begin
        failures++; $display("FAIL reset_mid_frame t=%0d got=%h exp=%h", t, got, exp);
      end
      if (restarted && t == 3) begin
        checks++;
        if (an_n !== 4'b0111) begin
          failures++; $display("FAIL reset_resume_anode got=%b exp=0111", an_n);
        end
      end
      if (i == 2 * SLOT + 9) begin
        reset = 1'b1; restarted = 1'b1;
      end
      advance();
    end
  endtask

  task automatic test_random();
    set_inputs(16'($urandom), 4'($urandom), 4'($urandom), 3'($urandom));
    reset = 1'b1; advance();
    for (int i = 0; i < 1500; i++) begin
      exp = expect_at(t); got = {an_n, seg_n, dp_n, frame_done}; checks++;
      if (got !== exp) begin
        failures++; $display("FAIL random t=%0d got=%h exp=%h", t, got, exp);
      end
      if ($urandom_range(0, 99) < 4)
        set_inputs(16'($urandom), 4'($urandom), 4'($urandom), 3'($urandom));
      if ($urandom_range(0, 399) == 0) reset = 1'b1;
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_brightness0();
    test_enable_partial();
    test_points();
    test_mid_frame();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
